dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory slave that answers the core load/store unit's request/grant/rvalid data interface. It is the memory end of the core's data-access protocol.
- Holds a word-addressed storage array and applies byte-enable writes.
- Returns in-order responses after a fixed latency. Flags out-of-range accesses so the core can raise EXC_CAUSE_LOAD_FAULT / EXC_CAUSE_STORE_FAULT.
- Instantiated in the SoC/testbench top beside the instruction memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be MEM_WORDS*4-aligned.
- LATENCY, 1, cycles from grant to rvalid; legal range 1..4.
- STALL_PERIOD, 0, 0 = grant never withheld; N>0 = grant forced low one cycle in every N.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_req_i  in  1  core request valid
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables (lane i = bits [8i+7:8i])
- data_wdata_i  in  32  store data, lane-aligned
- data_rvalid_o  out  1  response valid, one cycle per granted request
- data_rdata_o  out  32  load data, full word; 0 for stores and errors
- data_err_o  out  1  access fault, valid with rvalid

Behaviour:
- Reset (rst_i high at a clock edge): rvalid=0, rdata=0, err=0, stall counter=0, all pipeline valids cleared. Memory contents are NOT reset.
- Reset mid-operation: in-flight responses are dropped; no rvalid is produced for them.
- data_gnt_o is combinational: gnt = data_req_i & ~stall_now & ~rst_i.
- Stall counter:
  - Present only if STALL_PERIOD>0. Free-running 0..STALL_PERIOD-1, wraps to 0.
  - stall_now = (count == STALL_PERIOD-1).
  - STALL_PERIOD=1 means grant is never given; this setting is legal and used only for hang tests.
- Handshake: a transfer occurs on a cycle with req & gnt.
  - While gnt=0, the core holds req and all request fields stable; the responder relies on this and does not check it.
- Address decode:
  - in_range = (addr - BASE_ADDR) < MEM_WORDS*4, computed as a 32-bit unsigned subtract (wrap-around below BASE_ADDR counts as out of range).
  - word index = (addr - BASE_ADDR)[log2(MEM_WORDS)+1:2].
- On transfer, store in range: for each i with be[i]=1, mem[idx] byte i <= wdata byte i, committed at the granting edge. be=0000 is legal and writes nothing.
- On transfer, load in range: the full word mem[idx] is sampled at the granting edge. be does not mask rdata; the core does lane extraction.
- Out of range: no write. Response has err=1 and rdata=0.
- Response timing: a transfer at edge T produces rvalid=1 for exactly the cycle following edge T+LATENCY-1. LATENCY=1 gives rvalid in the cycle after the grant.
- Ordering: responses are strictly in grant order. Back-to-back grants give back-to-back rvalids.
- No response backpressure: the core always accepts rvalid.
- Outstanding requests are bounded implicitly by LATENCY; there is no outstanding-count throttle.
- Read-after-write: a load granted the cycle after a store to the same word returns the new data. One transfer per cycle, so there is no same-cycle conflict.
- When rvalid=0, rdata and err are driven 0, not held.

Decomposition:
- Add to core_pkg:
  - DMEM_ERR_NONE / DMEM_ERR_RANGE localparams.
  - A packed struct dmem_resp_t {logic valid; logic err; logic [31:0] rdata;}.
- Sub-module dmem_resp_pipe:
  - LATENCY-deep shift register of dmem_resp_t with synchronous active-high clear.
  - Parameterised by LATENCY; reused by the instruction-memory responder.
- The storage array, address decode and stall counter stay in dmem_responder.

Test Plan:
- Byte-enable store: reset, then store addr=0x10, be=1111, wdata=0xDEADBEEF; store addr=0x10, be=0100, wdata=0x00AA0000; load addr=0x10 -> rdata=0xDEAABEEF, err=0, rvalid exactly LATENCY cycles after the load's grant.
- Streaming: LATENCY=3, 8 consecutive loads with req held high (addresses 0x0..0x1C, preloaded data = addr) -> 8 consecutive rvalid cycles starting 3 cycles after the first grant, data in order.
- Out-of-range: BASE_ADDR=0x1000, MEM_WORDS=16.
  - Load 0x0FFC -> err=1, rdata=0.
  - Store 0x1040 -> err=1, and a later load of 0x1000 is unchanged.
  - Load 0x103C -> err=0.
- Stall: STALL_PERIOD=4, req held high for 12 cycles -> gnt low on cycles 3, 7, 11 after reset, 9 transfers total, 9 rvalids.
- Reset mid-flight: LATENCY=4, grant 2 loads, assert rst_i one cycle later -> no rvalid follows; memory written before reset is still readable afterwards.
- Read-after-write: store 0x20 = 0x12345678, immediately followed by load 0x20 -> rdata=0x12345678; the store's own response has rdata=0, err=0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and constants for the data-memory responder.
package dmem_responder_pkg;
  localparam logic DMEM_ERR_NONE  = 1'b0;
  localparam logic DMEM_ERR_RANGE = 1'b1;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dmem_resp_t;
endpackage

// File: rtl/dmem_resp_pipe.sv
// dmem_resp_pipe: LATENCY-deep response delay line with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high clear of every stage
//   resp_i : response entering the line at this edge
//   resp_o : response leaving the line (LATENCY edges after entry)
module dmem_resp_pipe
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  dmem_resp_t resp_i,
  output dmem_resp_t resp_o
);
  dmem_resp_t [LATENCY-1:0] pipe_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= resp_i;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign resp_o = pipe_q[LATENCY-1];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core req/gnt/rvalid data interface.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   data_req_i          : request valid
//   data_gnt_o          : request accepted this cycle (combinational)
//   data_addr_i         : byte address, bits [1:0] ignored
//   data_we_i           : 1 = store, 0 = load
//   data_be_i           : byte enables
//   data_wdata_i        : lane-aligned store data
//   data_rvalid_o       : one response cycle per granted request, in grant order
//   data_rdata_o        : full load word; 0 for stores, errors and idle cycles
//   data_err_o          : out-of-range access, valid with rvalid
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          LATENCY      = 1,
  parameter int          STALL_PERIOD = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic in_range, stall_now, xfer, unused_addr_lsb;
  dmem_resp_t resp_d, resp_q;
  // Subtract wraps for addresses below BASE_ADDR, which then land out of range.
  assign off = data_addr_i - BASE_ADDR;
  assign in_range = off[31:AW+2] == '0;
  assign idx = off[AW+1:2];
  assign unused_addr_lsb = ^off[1:0];
  assign data_gnt_o = data_req_i & ~stall_now & ~rst_i;
  assign xfer = data_gnt_o;
  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;
      logic [SW-1:0] cnt_q, cnt_d;
      assign stall_now = cnt_q == SW'(STALL_PERIOD - 1);
      assign cnt_d = stall_now ? '0 : cnt_q + SW'(1);
      always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
    end else begin : g_no_stall
      assign stall_now = 1'b0;
    end
  endgenerate
  always_ff @(posedge clk_i) begin
    if (xfer & data_we_i & in_range)
      for (int b = 0; b < 4; b++)
        if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
  end
  // Loads sample the array before this edge's write; only one transfer per cycle,
  // so a load never races its own store.
  always_comb begin
    resp_d.valid = xfer;
    resp_d.err   = xfer & (in_range ? DMEM_ERR_NONE : DMEM_ERR_RANGE);
    resp_d.rdata = (xfer & ~data_we_i & in_range) ? mem_q[idx] : '0;
  end
  dmem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .resp_i(resp_d),
    .resp_o(resp_q)
  );
  assign data_rvalid_o = resp_q.valid;
  assign data_rdata_o  = resp_q.rdata;
  assign data_err_o    = resp_q.err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scripted and randomized checks of dmem_responder.
module tb_dmem_responder;
  localparam int N = 128;
  logic clk = 0;
  always #5 clk = ~clk;
  logic a_rst, a_req, a_we, a_gnt, a_rv, a_err;
  logic b_rst, b_req, b_we, b_gnt, b_rv, b_err;
  logic [31:0] a_addr, a_wd, a_rd, b_addr, b_wd, b_rd;
  logic [3:0] a_be, b_be;
  dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3), .STALL_PERIOD(0)) u_a (
    .clk_i(clk), .rst_i(a_rst), .data_req_i(a_req), .data_gnt_o(a_gnt), .data_addr_i(a_addr),
    .data_we_i(a_we), .data_be_i(a_be), .data_wdata_i(a_wd), .data_rvalid_o(a_rv),
    .data_rdata_o(a_rd), .data_err_o(a_err));
  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1), .STALL_PERIOD(4)) u_b (
    .clk_i(clk), .rst_i(b_rst), .data_req_i(b_req), .data_gnt_o(b_gnt), .data_addr_i(b_addr),
    .data_we_i(b_we), .data_be_i(b_be), .data_wdata_i(b_wd), .data_rvalid_o(b_rv),
    .data_rdata_o(b_rd), .data_err_o(b_err));
  int checks = 0, failures = 0;
  logic s_rst [N], s_req [N], s_we [N];
  logic [31:0] s_addr [N], s_wd [N];
  logic [3:0] s_be [N];
  logic c_v [N], c_e [N], c_g [N];
  logic [31:0] c_d [N];
  task automatic clr();
    for (int i = 0; i < N; i++) begin
      s_rst[i] = 0; s_req[i] = 0; s_we[i] = 0; s_addr[i] = 0; s_wd[i] = 0; s_be[i] = 0;
      c_v[i] = 0; c_e[i] = 0; c_g[i] = 0; c_d[i] = 0;
    end
  endtask
  task automatic set(input int k, input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd);
    s_req[k] = 1; s_we[k] = we; s_addr[k] = addr; s_be[k] = be; s_wd[k] = wd;
  endtask
  task automatic apply(input bit use_b, input int k);
    if (use_b) begin
      b_rst = s_rst[k]; b_req = s_req[k]; b_we = s_we[k]; b_addr = s_addr[k]; b_be = s_be[k]; b_wd = s_wd[k];
    end else begin
      a_rst = s_rst[k]; a_req = s_req[k]; a_we = s_we[k]; a_addr = s_addr[k]; a_be = s_be[k]; a_wd = s_wd[k];
    end
  endtask
  // Script entry k is presented before edge k; capture k is the cycle after edge k.
  task automatic run(input bit use_b, input int n);
    @(negedge clk);
    apply(use_b, 0);
    #1 c_g[0] = use_b ? b_gnt : a_gnt;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c_v[k] = use_b ? b_rv : a_rv;
      c_d[k] = use_b ? b_rd : a_rd;
      c_e[k] = use_b ? b_err : a_err;
      apply(use_b, k + 1);
      #1 c_g[k+1] = use_b ? b_gnt : a_gnt;
    end
  endtask
  task automatic test_reset(input bit use_b);
    clr();
    for (int k = 0; k < 4; k++) begin
      s_rst[k] = 1;
      set(k, 1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    end
    run(use_b, 8);
    for (int k = 0; k < 4; k++) begin
      if (c_g[k] !== 1'b0) begin failures++; $display("FAIL reset_gnt b=%0d k=%0d got=%b exp=0", use_b, k, c_g[k]); end
      checks++;
    end
    for (int k = 0; k < 8; k++) begin
      if ({c_v[k], c_e[k], c_d[k]} !== 34'h0) begin
        failures++; $display("FAIL reset_out b=%0d k=%0d got v=%b e=%b d=%h exp all 0", use_b, k, c_v[k], c_e[k], c_d[k]);
      end
      checks++;
    end
  endtask
  task automatic test_byte_enable();
    clr();
    s_rst[0] = 1;
    set(1, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    set(2, 1, 32'h10, 4'h4, 32'h00AA_0000);
    set(3, 0, 32'h10, 4'h1, 32'h0);
    run(1, 6);
    for (int k = 0; k < 6; k++) begin
      if (c_v[k] !== (k >= 1 && k <= 3)) begin failures++; $display("FAIL be_rvalid k=%0d got=%b", k, c_v[k]); end
      checks++;
    end
    if (c_d[1] !== 0 || c_d[2] !== 0) begin failures++; $display("FAIL be_store_rdata got=%h,%h exp=0", c_d[1], c_d[2]); end
    checks++;
    if (c_d[3] !== 32'hDEAA_BEEF) begin failures++; $display("FAIL be_load_rdata got=%h exp=deaabeef", c_d[3]); end
    checks++;
    if (c_e[3] !== 1'b0) begin failures++; $display("FAIL be_load_err got=%b exp=0", c_e[3]); end
    checks++;
  endtask
  task automatic test_stall();
    int n_v = 0;
    bit eg;
    clr();
    s_rst[0] = 1;
    for (int k = 1; k <= 12; k++) set(k, 1, 32'h40, 4'hF, 32'h5A5A_5A5A);
    run(1, 15);
    for (int k = 1; k <= 12; k++) begin
      eg = ((k - 1) % 4) != 3;
      if (c_g[k] !== eg) begin failures++; $display("FAIL stall_gnt k=%0d got=%b exp=%b", k, c_g[k], eg); end
      checks++;
      if (c_v[k] !== eg) begin failures++; $display("FAIL stall_rvalid k=%0d got=%b exp=%b", k, c_v[k], eg); end
      checks++;
    end
    for (int k = 0; k < 15; k++) n_v += (c_v[k] === 1'b1) ? 1 : 0;
    if (n_v != 9) begin failures++; $display("FAIL stall_count got=%0d exp=9", n_v); end
    checks++;
  endtask
  task automatic test_out_of_range();
    clr();
    set(0, 1, 32'h1000, 4'hF, 32'h1111_2222);
    set(1, 0, 32'h0FFC, 4'hF, 32'h0);
    set(2, 1, 32'h1040, 4'hF, 32'hFFFF_FFFF);
    set(3, 0, 32'h103C, 4'hF, 32'h0);
    set(4, 0, 32'h1000, 4'hF, 32'h0);
    set(5, 0, 32'hFFFF_FFFC, 4'hF, 32'h0);
    run(0, 10);
    if (c_v[3] !== 1 || c_e[3] !== 1 || c_d[3] !== 0) begin failures++; $display("FAIL oor_below got v=%b e=%b d=%h exp v=1 e=1 d=0", c_v[3], c_e[3], c_d[3]); end
    checks++;
    if (c_v[4] !== 1 || c_e[4] !== 1 || c_d[4] !== 0) begin failures++; $display("FAIL oor_store got v=%b e=%b d=%h exp v=1 e=1 d=0", c_v[4], c_e[4], c_d[4]); end
    checks++;
    if (c_v[5] !== 1 || c_e[5] !== 0) begin failures++; $display("FAIL oor_top_word got v=%b e=%b exp v=1 e=0", c_v[5], c_e[5]); end
    checks++;
    if (c_e[6] !== 0 || c_d[6] !== 32'h1111_2222) begin failures++; $display("FAIL oor_unchanged got e=%b d=%h exp e=0 d=11112222", c_e[6], c_d[6]); end
    checks++;
    if (c_e[7] !== 1 || c_d[7] !== 0) begin failures++; $display("FAIL oor_wrap got e=%b d=%h exp e=1 d=0", c_e[7], c_d[7]); end
    checks++;
  endtask
  task automatic test_streaming();
    logic ev;
    logic [31:0] ed;
    clr();
    for (int i = 0; i < 8; i++) set(i, 1, 32'h1000 + 4 * i, 4'hF, 32'h1000 + 4 * i);
    for (int i = 0; i < 8; i++) set(8 + i, 0, 32'h1000 + 4 * i, 4'hF, 32'h0);
    run(0, 22);
    for (int k = 0; k < 22; k++) begin
      ev = k >= 2 && k <= 17;
      ed = (k >= 10 && k <= 17) ? 32'h1000 + 4 * (k - 10) : 32'h0;
      if (c_v[k] !== ev || c_d[k] !== ed) begin
        failures++; $display("FAIL stream k=%0d got v=%b d=%h exp v=%b d=%h", k, c_v[k], c_d[k], ev, ed);
      end
      checks++;
    end
  endtask
  task automatic test_raw();
    clr();
    set(0, 1, 32'h1020, 4'hF, 32'h1234_5678);
    set(1, 0, 32'h1020, 4'hF, 32'h0);
    run(0, 6);
    if (c_v[2] !== 1 || c_e[2] !== 0 || c_d[2] !== 0) begin failures++; $display("FAIL raw_store got v=%b e=%b d=%h exp v=1 e=0 d=0", c_v[2], c_e[2], c_d[2]); end
    checks++;
    if (c_v[3] !== 1 || c_d[3] !== 32'h1234_5678) begin failures++; $display("FAIL raw_load got v=%b d=%h exp v=1 d=12345678", c_v[3], c_d[3]); end
    checks++;
  endtask
  task automatic test_reset_midflight();
    clr();
    set(0, 1, 32'h1008, 4'hF, 32'hCAFE_F00D);
    set(1, 0, 32'h1008, 4'hF, 32'h0);
    set(2, 0, 32'h1008, 4'hF, 32'h0);
    s_rst[3] = 1;
    set(3, 0, 32'h1008, 4'hF, 32'h0);
    set(5, 0, 32'h1008, 4'hF, 32'h0);
    run(0, 10);
    if (c_v[2] !== 1) begin failures++; $display("FAIL mid_store_resp got=%b exp=1", c_v[2]); end
    checks++;
    if (c_g[3] !== 0) begin failures++; $display("FAIL mid_gnt_in_reset got=%b exp=0", c_g[3]); end
    checks++;
    for (int k = 3; k <= 6; k++) begin
      if (c_v[k] !== 0) begin failures++; $display("FAIL mid_dropped k=%0d got=%b exp=0", k, c_v[k]); end
      checks++;
    end
    if (c_v[7] !== 1 || c_d[7] !== 32'hCAFE_F00D) begin failures++; $display("FAIL mid_mem_kept got v=%b d=%h exp v=1 d=cafef00d", c_v[7], c_d[7]); end
    checks++;
  endtask
  task automatic test_random();
    logic [31:0] mm [16];
    logic ev [N], ee [N];
    logic [31:0] ed [N];
    logic [31:0] off;
    clr();
    for (int k = 0; k < N; k++) begin ev[k] = 0; ee[k] = 0; ed[k] = 0; end
    for (int k = 0; k < 16; k++) set(k, 1, 32'h1000 + 4 * k, 4'hF, $urandom);
    for (int k = 16; k < 76; k++)
      if ($urandom_range(0, 3) != 0)
        set(k, 1'($urandom_range(0, 1)), 32'h0FE0 + 4 * $urandom_range(0, 31), 4'($urandom_range(0, 15)), $urandom);
    run(0, 80);
    for (int k = 0; k < 78; k++) begin
      if (!s_req[k]) continue;
      off = s_addr[k] - 32'h1000;
      ev[k+2] = 1;
      if (off < 64) begin
        if (s_we[k]) begin
          for (int b = 0; b < 4; b++) if (s_be[k][b]) mm[off/4][8*b +: 8] = s_wd[k][8*b +: 8];
        end else ed[k+2] = mm[off/4];
      end else ee[k+2] = 1;
    end
    for (int k = 0; k < 80; k++) begin
      if (c_g[k] !== s_req[k]) begin failures++; $display("FAIL rand_gnt k=%0d got=%b exp=%b", k, c_g[k], s_req[k]); end
      checks++;
      if (k >= 2 && (c_v[k] !== ev[k] || c_e[k] !== ee[k] || c_d[k] !== ed[k])) begin
        failures++; $display("FAIL rand_resp k=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h", k, c_v[k], c_e[k], c_d[k], ev[k], ee[k], ed[k]);
      end
      if (k >= 2) checks++;
    end
  endtask
  initial begin
    a_rst = 1; a_req = 0; a_we = 0; a_addr = 0; a_be = 0; a_wd = 0;
    b_rst = 1; b_req = 0; b_we = 0; b_addr = 0; b_be = 0; b_wd = 0;
    repeat (2) @(posedge clk);
    test_reset(0);
    test_reset(1);
    test_byte_enable();
    test_stall();
    test_out_of_range();
    test_streaming();
    test_raw();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
